multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control FSM for the multicycle datapath. Decodes `Op`/`Funct` from the instruction register and sequences the datapath one phase per clock, driving the select lines for the shared-memory address mux, ALU source muxes, PC-source mux and write-back mux (`MemtoReg`). It also drives the write strobes for the PC, IR, register file and memory. Memory phases stall on a ready handshake.

## Interface
Parameters:
- none.

Ports:
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous active-low reset.
- `Op` in 6: instruction[31:26].
- `Funct` in 6: instruction[5:0].
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory access completes this cycle.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: memory write strobe.
- `IRWrite` out 1: IR load strobe.
- `RegDst` out 1: write-register select; 0 = rt, 1 = rd.
- `MemtoReg` out 1: write-back select; 0 = ALUOut, 1 = Data.
- `RegWrite` out 1: register-file write strobe.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `ALUSrcB` out 2: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUControl` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `PCSrc` out 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `PCEn` out 1: PC load enable.
- `Illegal` out 1: unsupported instruction pulse.
- `State` out 4: current state, for debug.

## Operation
- States (encoding):
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5.
  - EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Outputs not listed for a state are 0.
- FETCH:
  - IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00.
  - IRWrite = PCEn = `MemReady`.
  - Stay in FETCH while `MemReady`=0; go to DECODE when 1.
- DECODE: ALUSrcA=0, ALUSrcB=11, add. Next state by `Op`:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 (R-type) → EXECUTE.
  - 000100 (beq) → BRANCH.
  - 001000 (addi) → ADDIEX.
  - 000010 (j) → JUMP.
  - Any other `Op` → FETCH, with `Illegal`=1 this cycle.
- R-type `Funct` decode:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other `Funct` is illegal: FETCH, `Illegal`=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next: lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: IorD=1. Hold until `MemReady`=1, then → MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next → FETCH.
- MEMWRITE:
  - IorD=1; MemWrite=1 held every cycle in this state.
  - → FETCH on `MemReady`=1.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from `Funct`. Next → ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next → FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01.
  - PCEn = `Zero` (beq). Next → FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add. Next → ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next → FETCH.
- JUMP: PCSrc=10, PCEn=1. Next → FETCH.
- Unencoded states 12–15 → FETCH next cycle; all strobes 0 while in them.

## Timing
- State register updates on rising `clk`.
- All outputs are combinational from state. `PCEn`, `IRWrite`, `Illegal` and next state also depend on `MemReady`, `Zero`, `Op` and `Funct` in the same cycle.
- Reset:
  - `reset_n`=0 immediately forces State=FETCH.
  - While `reset_n` is low, every output is forced to 0, including strobes, selects and `State`.
  - First FETCH strobes appear in the first cycle after release.
- Reset mid-instruction aborts it. No partial write completes after reset assertion.
- Latency in cycles with `MemReady` always 1:
  - lw 5; sw, R-type, addi 4; beq, j 3.
  - Each `MemReady`=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- At most one of `RegWrite`/`MemWrite` is high in any cycle.

## Configuration
- `MC_BNE_EN` defined:
  - `Op`=000101 (bne) goes from DECODE → BRANCH.
  - In BRANCH, PCEn = ~`Zero` for bne and `Zero` for beq. The opcode is held internally from DECODE.
- `MC_BNE_EN` undefined: 000101 is illegal (FETCH, `Illegal`=1).

## Test plan
- Reset asserted in EXECUTE, released → all outputs 0 during reset. Cycle 1 after release: State=0, IRWrite=1, PCEn=1 (`MemReady`=1).
- lw (Op=100011), MemReady low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0. MemtoReg=1 and RegWrite=1 only in state 4. Total 7 cycles.
- R-type sub (Funct=100010) → ALUControl=110 in EXECUTE; ALUWB has RegDst=1, MemtoReg=0, RegWrite=1.
- beq with Zero=1 → PCEn=1, PCSrc=01 in BRANCH. With Zero=0 → PCEn=0. Both take 3 cycles.
- Op=111111 → DECODE drives Illegal=1, then FETCH. No RegWrite/MemWrite asserted.
- bne (Op=000101), Zero=0:
  - `MC_BNE_EN` defined → PCEn=1 in BRANCH.
  - Undefined → Illegal=1 in DECODE.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle datapath: one phase per clock, memory phases stall on MemReady.
// Optional `MC_BNE_EN` adds bne (Op=000101) through the BRANCH state.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    state_t state;
    state_t state_next;

    logic       iord_d, memwrite_d, irwrite_d, regdst_d, memtoreg_d, regwrite_d;
    logic       alusrca_d, pcen_d, illegal_d;
    logic [1:0] alusrcb_d, pcsrc_d;
    logic [2:0] aluctrl_d;

    logic [2:0] funct_ctrl;
    logic       funct_ok;
    logic       bne_op;
    logic       branch_take;

    always_comb begin
        funct_ok   = 1'b1;
        funct_ctrl = ALU_ADD;
        case (Funct)
            6'b100000: funct_ctrl = ALU_ADD;
            6'b100010: funct_ctrl = ALU_SUB;
            6'b100100: funct_ctrl = 3'b000;
            6'b100101: funct_ctrl = 3'b001;
            6'b101010: funct_ctrl = 3'b111;
            default:   funct_ok   = 1'b0;
        endcase
    end

`ifdef MC_BNE_EN
    // Op may change once the IR is reloaded, so the branch sense is captured in DECODE.
    logic bne_held;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bne_held <= 1'b0;
        else if (state == DECODE)
            bne_held <= (Op == OP_BNE);
    end

    assign bne_op      = (Op == OP_BNE);
    assign branch_take = bne_held ? ~Zero : Zero;
`else
    assign bne_op      = 1'b0;
    assign branch_take = Zero;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        iord_d     = 1'b0;
        memwrite_d = 1'b0;
        irwrite_d  = 1'b0;
        regdst_d   = 1'b0;
        memtoreg_d = 1'b0;
        regwrite_d = 1'b0;
        alusrca_d  = 1'b0;
        alusrcb_d  = 2'b00;
        aluctrl_d  = 3'b000;
        pcsrc_d    = 2'b00;
        pcen_d     = 1'b0;
        illegal_d  = 1'b0;
        case (state)
            FETCH: begin
                alusrcb_d  = 2'b01;
                aluctrl_d  = ALU_ADD;
                irwrite_d  = MemReady;
                pcen_d     = MemReady;
                state_next = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb_d = 2'b11;
                aluctrl_d = ALU_ADD;
                if (Op == OP_LW || Op == OP_SW)
                    state_next = MEMADR;
                else if (Op == OP_RTYPE && funct_ok)
                    state_next = EXECUTE;
                else if (Op == OP_BEQ || bne_op)
                    state_next = BRANCH;
                else if (Op == OP_ADDI)
                    state_next = ADDIEX;
                else if (Op == OP_J)
                    state_next = JUMP;
                else
                    illegal_d = 1'b1;
            end
            MEMADR: begin
                alusrca_d  = 1'b1;
                alusrcb_d  = 2'b10;
                aluctrl_d  = ALU_ADD;
                state_next = (Op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                iord_d     = 1'b1;
                state_next = MemReady ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                memtoreg_d = 1'b1;
                regwrite_d = 1'b1;
            end
            MEMWRITE: begin
                iord_d     = 1'b1;
                memwrite_d = 1'b1;
                state_next = MemReady ? FETCH : MEMWRITE;
            end
            EXECUTE: begin
                alusrca_d  = 1'b1;
                aluctrl_d  = funct_ctrl;
                state_next = ALUWB;
            end
            ALUWB: begin
                regdst_d   = 1'b1;
                regwrite_d = 1'b1;
            end
            BRANCH: begin
                alusrca_d = 1'b1;
                aluctrl_d = ALU_SUB;
                pcsrc_d   = 2'b01;
                pcen_d    = branch_take;
            end
            ADDIEX: begin
                alusrca_d  = 1'b1;
                alusrcb_d  = 2'b10;
                aluctrl_d  = ALU_ADD;
                state_next = ADDIWB;
            end
            ADDIWB: regwrite_d = 1'b1;
            JUMP: begin
                pcsrc_d = 2'b10;
                pcen_d  = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    // Everything is gated by reset_n so no strobe survives reset assertion.
    assign IorD       = reset_n & iord_d;
    assign MemWrite   = reset_n & memwrite_d;
    assign IRWrite    = reset_n & irwrite_d;
    assign RegDst     = reset_n & regdst_d;
    assign MemtoReg   = reset_n & memtoreg_d;
    assign RegWrite   = reset_n & regwrite_d;
    assign ALUSrcA    = reset_n & alusrca_d;
    assign ALUSrcB    = reset_n ? alusrcb_d : 2'b00;
    assign ALUControl = reset_n ? aluctrl_d : 3'b000;
    assign PCSrc      = reset_n ? pcsrc_d : 2'b00;
    assign PCEn       = reset_n & pcen_d;
    assign Illegal    = reset_n & illegal_d;
    assign State      = reset_n ? state : 4'd0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; inputs change 1 time unit after the rising edge,
// outputs are checked 1 time unit after that.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] Op, Funct;
    logic       Zero, MemReady;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, Illegal;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;
    logic [19:0] outs;

    int n_checks = 0;
    int n_errors = 0;
    int cycles = 0;
    int start;

    logic [5:0] r_funct [5];
    logic [2:0] r_ctrl  [5];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal), .State(State)
    );

    assign outs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
                   ALUControl, PCSrc, PCEn, Illegal, State};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycles++;
    endtask

    always @(negedge clk)
        if (reset_n === 1'b1)
            check("wr_excl", {31'd0, RegWrite & MemWrite}, 32'd0);

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        r_funct[0] = 6'b100000; r_ctrl[0] = 3'b010;
        r_funct[1] = 6'b100010; r_ctrl[1] = 3'b110;
        r_funct[2] = 6'b100100; r_ctrl[2] = 3'b000;
        r_funct[3] = 6'b100101; r_ctrl[3] = 3'b001;
        r_funct[4] = 6'b101010; r_ctrl[4] = 3'b111;

        reset_n = 1'b0; Op = 6'b111111; Funct = 6'd0; Zero = 1'b0; MemReady = 1'b1;
        repeat (2) tick();
        check("rst_outs", outs, 20'd0);
        reset_n = 1'b1; #1;
        check("rel_state", State, 4'd0);
        check("rel_irwrite", IRWrite, 1'b1);
        check("rel_pcen", PCEn, 1'b1);
        check("fetch_srcb", ALUSrcB, 2'b01);
        check("fetch_alu", ALUControl, 3'b010);

        // FETCH stall
        MemReady = 1'b0; #1;
        check("fstall_irwrite", IRWrite, 1'b0);
        check("fstall_pcen", PCEn, 1'b0);
        tick();
        check("fstall_state", State, 4'd0);
        MemReady = 1'b1;

        // lw with two MEMREAD stalls
        Op = 6'b100011; #1; start = cycles;
        tick(); check("lw_dec", State, 4'd1); check("lw_dec_srcb", ALUSrcB, 2'b11);
        tick(); check("lw_madr", State, 4'd2); check("lw_madr_srcb", ALUSrcB, 2'b10);
        check("lw_madr_srca", ALUSrcA, 1'b1);
        tick(); MemReady = 1'b0; #1;
        check("lw_mrd0", State, 4'd3); check("lw_mrd_iord", IorD, 1'b1);
        check("lw_mrd_rw", RegWrite, 1'b0);
        tick(); check("lw_mrd1", State, 4'd3);
        tick(); MemReady = 1'b1; #1; check("lw_mrd2", State, 4'd3);
        tick(); check("lw_wb", State, 4'd4); check("lw_wb_m2r", MemtoReg, 1'b1);
        check("lw_wb_rw", RegWrite, 1'b1); check("lw_wb_rdst", RegDst, 1'b0);
        tick(); check("lw_end", State, 4'd0); check("lw_lat", cycles - start, 7);

        // R-type, all supported functs
        for (int i = 0; i < 5; i++) begin
            Op = 6'b000000; Funct = r_funct[i]; #1; start = cycles;
            tick(); check("r_dec", State, 4'd1);
            tick(); check("r_exe", State, 4'd6); check("r_exe_alu", ALUControl, r_ctrl[i]);
            check("r_exe_srcb", ALUSrcB, 2'b00); check("r_exe_srca", ALUSrcA, 1'b1);
            tick(); check("r_wb", State, 4'd7); check("r_wb_rdst", RegDst, 1'b1);
            check("r_wb_m2r", MemtoReg, 1'b0); check("r_wb_rw", RegWrite, 1'b1);
            tick(); check("r_end", State, 4'd0); check("r_lat", cycles - start, 4);
        end

        // illegal funct
        Funct = 6'b000000; #1;
        tick(); check("rbad_ill", Illegal, 1'b1); check("rbad_state", State, 4'd1);
        tick(); check("rbad_end", State, 4'd0);

        // beq taken and not taken
        for (int z = 1; z >= 0; z--) begin
            Op = 6'b000100; Zero = z[0]; #1; start = cycles;
            tick(); check("beq_dec", State, 4'd1);
            tick(); check("beq_br", State, 4'd8); check("beq_pcen", PCEn, z[0]);
            check("beq_pcsrc", PCSrc, 2'b01); check("beq_alu", ALUControl, 3'b110);
            tick(); check("beq_end", State, 4'd0); check("beq_lat", cycles - start, 3);
        end

        // sw with one MEMWRITE stall
        Op = 6'b101011; Zero = 1'b0; #1; start = cycles;
        tick(); tick(); check("sw_madr", State, 4'd2);
        tick(); MemReady = 1'b0; #1;
        check("sw_mw0", State, 4'd5); check("sw_mw0_we", MemWrite, 1'b1); check("sw_iord", IorD, 1'b1);
        tick(); MemReady = 1'b1; #1;
        check("sw_mw1", State, 4'd5); check("sw_mw1_we", MemWrite, 1'b1);
        tick(); check("sw_end", State, 4'd0); check("sw_lat", cycles - start, 5);

        // addi
        Op = 6'b001000; #1; start = cycles;
        tick(); tick(); check("addi_ex", State, 4'd9); check("addi_srcb", ALUSrcB, 2'b10);
        tick(); check("addi_wb", State, 4'd10); check("addi_rw", RegWrite, 1'b1);
        check("addi_rdst", RegDst, 1'b0);
        tick(); check("addi_end", State, 4'd0); check("addi_lat", cycles - start, 4);

        // j
        Op = 6'b000010; #1; start = cycles;
        tick(); tick(); check("j_state", State, 4'd11); check("j_pcsrc", PCSrc, 2'b10);
        check("j_pcen", PCEn, 1'b1);
        tick(); check("j_end", State, 4'd0); check("j_lat", cycles - start, 3);

        // unsupported opcode
        Op = 6'b111111; #1;
        tick(); check("ill_flag", Illegal, 1'b1); check("ill_wr", {RegWrite, MemWrite}, 2'b00);
        tick(); check("ill_end", State, 4'd0); check("ill_flag_clr", Illegal, 1'b0);

        // bne with Zero=0
        Op = 6'b000101; Zero = 1'b0; #1;
        tick();
`ifdef MC_BNE_EN
        check("bne_dec_ill", Illegal, 1'b0);
        tick(); check("bne_br", State, 4'd8); check("bne_pcen", PCEn, 1'b1);
`else
        check("bne_dec_ill", Illegal, 1'b1);
`endif
        tick(); check("bne_end", State, 4'd0);

        // reset in EXECUTE
        Op = 6'b000000; Funct = 6'b100000; #1;
        tick(); tick(); check("rx_exe", State, 4'd6);
        reset_n = 1'b0; #1;
        check("rx_outs0", outs, 20'd0);
        tick(); check("rx_outs1", outs, 20'd0);
        reset_n = 1'b1; #1;
        check("rx_state", State, 4'd0);
        check("rx_irwrite", IRWrite, 1'b1);
        check("rx_pcen", PCEn, 1'b1);
        check("rx_rw", RegWrite, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
